// File: rtl/vslc_exec_core.sv
// rtl/vslc_exec_core.sv - VSLC ladder-logic bytecode executor on a 1-bit stack
// One bytecode byte per instr_valid beat; parameter loads stream 1-2 data bytes.
module vslc_exec_core #(
  parameter int STACK_DEPTH = 16,
  parameter int SFR_W       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 instr_valid,
  input  logic [7:0]                           instr,
  input  logic [7:0]                           ui_in,
  input  logic [7:0]                           ui_in_prev,
  input  logic [SFR_W-1:0]                     sfr_hw_we,
  input  logic [SFR_W-1:0]                     sfr_hw_d,
  output logic [7:0]                           uo_out,
  output logic [SFR_W-1:0]                     sfr_q,
  output logic [STACK_DEPTH-1:0]               stack_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
  output logic                                 ovf,
  output logic                                 unf,
  input  logic                                 err_clr,
  output logic                                 param_we,
  output logic [2:0]                           param_addr,
  output logic [1:0]                           param_be,
  output logic [15:0]                          param_data
);

  localparam int DW = $clog2(STACK_DEPTH+1);

  typedef enum logic [1:0] {EXEC, P_LO, P_HI} state_t;
  state_t state, state_n;

  logic       p_two, p_cond;
  logic [2:0] p_addr;
  logic [7:0] p_lo;
  logic       p_start, strobe;

  logic                   exec;
  logic [STACK_DEPTH-1:0] opnd, stk_n;
  logic                   tos, nos, hos;
  logic [7:0]             uo_n;
  logic [15:0]            sfr16, sfr16_n;
  logic [SFR_W-1:0]       sfr_n;
  logic [DW-1:0]          depth_n;
  logic                   ovf_ev, unf_ev;
  logic                   rbit, fbit;
  logic [1:0]             lidx;
  logic [2:0]             r;
  logic [3:0]             f;
  int                     need, net, dn;
  logic                   force_d;
  logic [DW-1:0]          forced_d;

  assign exec  = instr_valid && (state == EXEC);
  assign r     = instr[2:0];
  assign f     = instr[3:0];
  assign sfr16 = 16'(sfr_q);

  // Bits at or beyond the occupancy count are read as 0.
  always_comb begin
    opnd = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      opnd[i] = stack_out[i] && (i < int'(depth));
  end
  assign tos  = opnd[0];
  assign nos  = opnd[1];
  assign hos  = opnd[2];
  assign lidx = 2'd3 - {nos, tos};
  assign fbit = instr[lidx];

  always_comb begin
    stk_n    = stack_out;
    uo_n     = uo_out;
    sfr16_n  = sfr16;
    need     = 0;
    net      = 0;
    force_d  = 1'b0;
    forced_d = '0;
    rbit     = 1'b0;
    if (exec) begin
      case (instr[7:6])
        2'b00, 2'b01: begin
          if (instr[6]) rbit = sfr16[f];
          else          rbit = instr[3] ? uo_out[r] : ui_in[r];
          if (instr[5:4] == 2'b00) begin
            stk_n = {stack_out[STACK_DEPTH-2:0], rbit};
            net   = 1;
          end else begin
            stk_n = {1'b0, stack_out[STACK_DEPTH-1:1]};
            need  = 1;
            net   = -1;
            if (instr[6]) begin
              if (instr[5:4] == 2'b01) sfr16_n[f] = tos;
              else if (tos)            sfr16_n[f] = !instr[4];
            end else begin
              if (instr[5:4] == 2'b01) uo_n[r] = tos;
              else if (tos)            uo_n[r] = !instr[4];
            end
          end
        end
        2'b10: begin
          case (instr[5:4])
            2'b00: begin need = 2; stk_n[0] = fbit; end
            2'b01: begin
              need  = 2;
              net   = -1;
              stk_n = {1'b0, stack_out[STACK_DEPTH-1:2], fbit};
            end
            2'b11: begin
              need  = 2;
              net   = 1;
              stk_n = {stack_out[STACK_DEPTH-2:0], fbit};
            end
            default: ;
          endcase
        end
        default: begin
          if (!instr[5]) begin
            stk_n = {stack_out[STACK_DEPTH-2:0],
                     (ui_in[r] == !instr[4]) && (ui_in_prev[r] == instr[4])};
            net   = 1;
          end else if (instr[4]) begin
            case (instr[3:0])
              4'h0: begin stk_n = '0; force_d = 1'b1; forced_d = '0; end
              4'h1: begin stk_n = '1; force_d = 1'b1; forced_d = DW'(STACK_DEPTH); end
              4'h2: begin need = 2; stk_n[0] = nos; stk_n[1] = tos; end
              4'h3: begin need = 3; stk_n[0] = nos; stk_n[1] = hos; stk_n[2] = tos; end
              4'h4: begin need = 1; net = 1; stk_n = {stack_out[STACK_DEPTH-2:0], tos}; end
              4'h5: begin need = 1; net = -1; stk_n = {1'b0, stack_out[STACK_DEPTH-1:1]}; end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    dn     = int'(depth) + net;
    unf_ev = exec && (int'(depth) < need);
    ovf_ev = exec && (dn > STACK_DEPTH);
    if (force_d)               depth_n = forced_d;
    else if (dn < 0)           depth_n = '0;
    else if (dn > STACK_DEPTH) depth_n = DW'(STACK_DEPTH);
    else                       depth_n = DW'(dn);
  end

  // Peripheral status writes override instruction writes bit by bit.
  assign sfr_n = (sfr16_n[SFR_W-1:0] & ~sfr_hw_we) | (sfr_hw_d & sfr_hw_we);

  always_comb begin
    state_n = state;
    p_start = 1'b0;
    strobe  = 1'b0;
    case (state)
      EXEC: if (instr_valid && instr[7:4] == 4'b1110) begin
        state_n = P_LO;
        p_start = 1'b1;
      end
      P_LO: if (instr_valid) begin
        if (p_two) state_n = P_HI;
        else begin
          state_n = EXEC;
          strobe  = 1'b1;
        end
      end
      P_HI: if (instr_valid) begin
        state_n = EXEC;
        strobe  = 1'b1;
      end
      default: state_n = EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EXEC;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stack_out  <= '0;
      depth      <= '0;
      uo_out     <= '0;
      sfr_q      <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      p_two      <= 1'b0;
      p_cond     <= 1'b0;
      p_addr     <= '0;
      p_lo       <= '0;
      param_we   <= 1'b0;
      param_addr <= '0;
      param_be   <= '0;
      param_data <= '0;
    end else begin
      stack_out <= stk_n;
      depth     <= depth_n;
      uo_out    <= uo_n;
      sfr_q     <= sfr_n;
      ovf       <= ovf_ev | (ovf & !err_clr);
      unf       <= unf_ev | (unf & !err_clr);
      param_we  <= strobe && p_cond;
      if (p_start) begin
        p_two  <= instr[3];
        p_addr <= instr[2:0];
        p_cond <= tos;
      end
      if (state == P_LO && instr_valid) p_lo <= instr;
      if (strobe && p_cond) begin
        param_addr <= p_addr;
        param_be   <= p_two ? 2'b11 : 2'b01;
        param_data <= p_two ? {instr, p_lo} : {8'h00, instr};
      end
    end
  end

endmodule

// File: tb/tb_vslc_exec_core.sv
// tb/tb_vslc_exec_core.sv - directed self-checking bench for vslc_exec_core
module tb_vslc_exec_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [7:0]  instr;
  logic [7:0]  ui_in;
  logic [7:0]  ui_in_prev;
  logic [15:0] sfr_hw_we;
  logic [15:0] sfr_hw_d;
  logic [7:0]  uo_out;
  logic [15:0] sfr_q;
  logic [15:0] stack_out;
  logic [4:0]  depth;
  logic        ovf, unf;
  logic        err_clr;
  logic        param_we;
  logic [2:0]  param_addr;
  logic [1:0]  param_be;
  logic [15:0] param_data;

  int n_cmp = 0;
  int n_bad = 0;

  vslc_exec_core #(.STACK_DEPTH(16), .SFR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .ui_in(ui_in), .ui_in_prev(ui_in_prev), .sfr_hw_we(sfr_hw_we), .sfr_hw_d(sfr_hw_d),
    .uo_out(uo_out), .sfr_q(sfr_q), .stack_out(stack_out), .depth(depth),
    .ovf(ovf), .unf(unf), .err_clr(err_clr), .param_we(param_we),
    .param_addr(param_addr), .param_be(param_be), .param_data(param_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] b);
    instr       = b;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ui_in = 8'h04; ui_in_prev = 8'h00;
    sfr_hw_we = '0; sfr_hw_d = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_uo", uo_out, 0);
    chk("rst_stack", stack_out, 0);
    chk("rst_depth", depth, 0);
    chk("rst_flags", {ovf, unf, param_we}, 0);

    step(8'h02);
    chk("push_depth", depth, 1);
    chk("push_stack", stack_out, 16'h0001);
    step(8'h15);
    chk("pop_uo", uo_out, 8'h20);
    chk("pop_depth", depth, 0);
    chk("pop_flags", {ovf, unf}, 0);

    step(8'h00);
    step(8'h02);
    step(8'h96);
    chk("xor_stack", stack_out, 16'h0001);
    chk("xor_depth", depth, 1);

    step(8'h53);
    chk("sfr_pop", sfr_q, 16'h0008);
    step(8'h0D);
    chk("push_uo_bit", stack_out, 16'h0001);
    sfr_hw_we = 16'h0010; sfr_hw_d = 16'h0000;
    step(8'h64);
    sfr_hw_we = '0;
    chk("sfr_hw_wins", sfr_q, 16'h0008);
    chk("sfr_set_depth", depth, 0);

    step(8'h15);
    chk("unf_uo", uo_out, 8'h00);
    chk("unf_flag", unf, 1);
    chk("unf_depth", depth, 0);
    err_clr = 1'b1; idle(); err_clr = 1'b0;
    chk("unf_clr", unf, 0);

    repeat (16) step(8'h02);
    chk("full_depth", depth, 16);
    chk("full_stack", stack_out, 16'hFFFF);
    chk("full_noovf", ovf, 0);
    step(8'h02);
    chk("ovf_flag", ovf, 1);
    chk("ovf_depth", depth, 16);
    err_clr = 1'b1; idle(); err_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    err_clr = 1'b1; step(8'h02); err_clr = 1'b0;
    chk("ovf_err_wins", ovf, 1);
    err_clr = 1'b1; idle(); err_clr = 1'b0;

    step(8'hF0);
    chk("clr_stack", stack_out, 0);
    chk("clr_depth", depth, 0);
    step(8'hC2);
    step(8'hD2);
    chk("edge_stack", stack_out, 16'h0002);
    chk("edge_depth", depth, 2);
    step(8'hF2);
    chk("swap_stack", stack_out, 16'h0001);
    step(8'h00);
    chk("pre_rot", stack_out, 16'h0002);
    step(8'hF3);
    chk("rot_stack", stack_out, 16'h0001);
    chk("rot_depth", depth, 3);

    step(8'hF0);
    step(8'h02);
    step(8'hE9);
    chk("pl_hdr_we", param_we, 0);
    chk("pl_hdr_stack", stack_out, 16'h0001);
    step(8'h34);
    chk("pl_lo_we", param_we, 0);
    chk("pl_lo_depth", depth, 1);
    step(8'h12);
    chk("pl_we", param_we, 1);
    chk("pl_addr", param_addr, 1);
    chk("pl_be", param_be, 2'b11);
    chk("pl_data", param_data, 16'h1234);
    chk("pl_depth", depth, 1);
    idle();
    chk("pl_we_pulse", param_we, 0);
    chk("pl_data_hold", param_data, 16'h1234);

    step(8'hF0);
    step(8'h00);
    step(8'hE0);
    step(8'h15);
    chk("nc_we", param_we, 0);
    chk("nc_skip_depth", depth, 1);
    chk("nc_data_hold", param_data, 16'h1234);

    step(8'h02);
    step(8'hE9);
    step(8'h34);
    rst_n = 1'b0; idle(); rst_n = 1'b1;
    chk("rmid_we", param_we, 0);
    chk("rmid_depth", depth, 0);
    chk("rmid_data", param_data, 0);
    step(8'h02);
    chk("rmid_opcode", stack_out, 16'h0001);
    chk("rmid_op_depth", depth, 1);
    chk("rmid_no_we", param_we, 0);

    step(8'hE2);
    step(8'hAB);
    chk("p1_we", param_we, 1);
    chk("p1_addr", param_addr, 2);
    chk("p1_be", param_be, 2'b01);
    chk("p1_data", param_data, 16'h00AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
